bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares the single binary-to-BCD converter between NREQ independent requesters, e.g. several counters feeding a display. Each request snapshots a binary value and queues it. A round-robin scheduler issues one conversion at a time, waits for the converter's ready, and files the BCD result into a per-requester result register with a one-cycle valid strobe. A watchdog recovers the arbiter if the converter never answers.

Parameters:
NREQ, 4, number of requesters (2..8)
BIN_W, 12, binary operand width
BCD_W, 16, BCD result width (4 digits)
TIMEOUT, 64, max cycles to wait for conv_rdy after issue (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester request strobe; sampled every cycle
bin_in  in  NREQ*BIN_W  operands, channel i at [i*BIN_W +: BIN_W]
conv_en  out  1  start strobe to converter
conv_bin  out  BIN_W  operand to converter, held stable from issue until rdy/timeout
conv_bcd  in  BCD_W  converter result
conv_rdy  in  1  converter result-valid strobe
res_bcd  out  NREQ*BCD_W  last result per channel, channel i at [i*BCD_W +: BCD_W]
res_valid  out  NREQ  one-cycle strobe: res_bcd channel i just updated
busy  out  1  high when state != IDLE or any pending bit set
err  out  1  one-cycle strobe on watchdog timeout

Behaviour:
- Reset: all outputs 0. Pending bits, snapshots, results and counters are 0. State is IDLE. Round-robin pointer = NREQ-1, so channel 0 wins first.
- Request capture: on any edge where req[i]=1:
  - pending[i] <= 1
  - snap[i] <= bin_in[i]
  - A later request before issue overwrites snap[i] (latest value wins; no duplicate queuing).
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE:
  - If pending != 0, grant the first set bit searching ptr+1, ptr+2, ... (mod NREQ).
  - Latch grant index ch and conv_bin <= snap[ch].
  - Go to ISSUE.
  - Registered pending bits are used, so a request seen at edge t is eligible at edge t+1.
- ISSUE (1 cycle):
  - conv_en = 1.
  - Clear pending[ch], unless req[ch]=1 this same cycle; then pending stays set and snap is updated for a later round.
  - Watchdog cleared. Go to WAIT.
- WAIT:
  - conv_en = 0. Watchdog increments each cycle.
  - On conv_rdy=1: capture conv_bcd, go to STORE.
  - Else if watchdog reaches TIMEOUT-1: err = 1 for one cycle, ptr <= ch, go to IDLE. The result register is not changed and the request is dropped.
  - conv_rdy in any other state is ignored.
- STORE (1 cycle):
  - res_bcd[ch] <= captured value.
  - res_valid[ch] = 1 in the cycle after the write edge, so the strobe aligns with the new data.
  - ptr <= ch. Go to IDLE.
- Latency: request edge t -> conv_en high in cycle t+2. Converter latency L (rdy L cycles after en) -> res_valid in cycle t+2+L+2.
- Fairness: any pending channel is served within NREQ-1 other conversions.
- conv_bin is held constant from ISSUE through exit from WAIT.
- Reset mid-operation: immediate return to IDLE. Pending bits are lost and res_bcd cleared. An in-flight conv_rdy after reset is ignored.
- No arithmetic on data; widths pass through unchanged.

Test Plan:
- Single request: req[1] pulse with bin 12'd987; converter model L=14 -> conv_en once, conv_bin=987, res_bcd ch1=16'h0987, res_valid=4'b0010 for one cycle, others unchanged, err=0.
- Simultaneous: req=4'b1111 with bins 1, 22, 333, 4095 in one cycle -> conversions issued in order 0,1,2,3. Results 16'h0001, 16'h0022, 16'h0333, 16'h4095. Exactly four conv_en pulses.
- Round-robin: keep req[0] and req[2] asserted continuously -> grants alternate 0,2,0,2; neither channel is served twice in a row.
- Overwrite: req[3] bin=5, then req[3] bin=9 while channel 0 is converting -> one conversion for ch3, result 16'h0009.
- Timeout: converter never asserts rdy after req[2] bin=100 -> err pulses exactly TIMEOUT cycles after conv_en, res_bcd ch2 stays 0. A following req[2] bin=100 with a working model gives 16'h0100.
- Reset mid-WAIT: rst for one cycle during WAIT, then model asserts rdy -> all outputs 0, no res_valid, state IDLE.

Source files
------------

// File: rtl/bcd_conv_arbiter_if.sv
// Bus bundle between the requesters/converter side and the BCD conversion
// arbiter. The arbiter uses the slave modport, the environment the master.
interface bcd_conv_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int BIN_W = 12,
  parameter int BCD_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] bin_in;
  logic                  conv_en;
  logic [BIN_W-1:0]      conv_bin;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_rdy;
  logic [NREQ*BCD_W-1:0] res_bcd;
  logic [NREQ-1:0]       res_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output req, bin_in, conv_bcd, conv_rdy,
    input  conv_en, conv_bin, res_bcd, res_valid, busy, err
  );

  modport slave (
    input  req, bin_in, conv_bcd, conv_rdy,
    output conv_en, conv_bin, res_bcd, res_valid, busy, err
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among NREQ
// requesters. Requests snapshot their operand; one conversion is in flight
// at a time; results land in per-channel registers with a valid strobe.
// A watchdog abandons a conversion the converter never answers.
module bcd_conv_arbiter #(
  parameter int NREQ    = 4,
  parameter int BIN_W   = 12,
  parameter int BCD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  bcd_conv_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t                state_q, state_d;
  logic [NREQ-1:0]       pend_q, pend_d;
  logic [BIN_W-1:0]      snap_q [NREQ];
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         ch_q, ch_d;
  logic [BIN_W-1:0]      cbin_q, cbin_d;
  logic [BCD_W-1:0]      cap_q, cap_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic [NREQ*BCD_W-1:0] res_q;
  logic [NREQ-1:0]       rv_q;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_found;
  logic                  timeout;
  logic                  conv_en_d;
  logic                  err_d;

  // Round-robin search: first pending channel after the last one served.
  always_comb begin
    int            idx;
    logic [PW-1:0] ip;
    idx       = 0;
    ip        = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      ip  = PW'(idx);
      if (!gnt_found && pend_q[ip]) begin
        gnt_found = 1'b1;
        gnt_idx   = ip;
      end
    end
  end

  assign timeout = (state_q == S_WAIT) && !bus.conv_rdy && (wd_q == WW'(TIMEOUT - 1));

  // Next-state, pending bookkeeping and converter strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    cbin_d    = cbin_q;
    cap_d     = cap_q;
    wd_d      = wd_q;
    pend_d    = pend_q;
    conv_en_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ch_d    = gnt_idx;
          cbin_d  = snap_q[gnt_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        conv_en_d    = 1'b1;
        pend_d[ch_q] = 1'b0;
        wd_d         = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.conv_rdy) begin
          cap_d   = bus.conv_bcd;
          state_d = S_STORE;
        end else if (timeout) begin
          // Give up on this request; the result register keeps its old value.
          err_d   = 1'b1;
          ptr_d   = ch_q;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_STORE: begin
        ptr_d   = ch_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request this cycle always re-arms its channel, even the one issuing.
    pend_d = pend_d | bus.req;
  end

  // State, snapshots and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ptr_q   <= PW'(NREQ - 1);
      ch_q    <= '0;
      cbin_q  <= '0;
      cap_q   <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      rv_q    <= '0;
      for (int i = 0; i < NREQ; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      cbin_q  <= cbin_d;
      cap_q   <= cap_d;
      wd_q    <= wd_d;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) snap_q[i] <= bus.bin_in[i*BIN_W +: BIN_W];
      end
      rv_q <= '0;
      if (state_q == S_STORE) begin
        res_q[int'(ch_q)*BCD_W +: BCD_W] <= cap_q;
        rv_q[ch_q]                       <= 1'b1;
      end
    end
  end

  assign bus.conv_en   = conv_en_d;
  assign bus.err       = err_d;
  assign bus.conv_bin  = cbin_q;
  assign bus.res_bcd   = res_q;
  assign bus.res_valid = rv_q;
  assign bus.busy      = (state_q != S_IDLE) || (|pend_q);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter with a behavioural converter
// model and a transaction monitor.
module tb_bcd_conv_arbiter;
  localparam int NREQ    = 4;
  localparam int BIN_W   = 12;
  localparam int BCD_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;

  bcd_conv_arbiter_if #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W)) bif ();

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int lat = 5;
  bit alive = 1'b1;
  int req_obs = 0;
  int last_served = NREQ - 1;
  logic [BIN_W-1:0] pbin [NREQ];
  logic [BCD_W-1:0] exp_res [NREQ];

  int en_bin [$];
  int en_cyc [$];
  int err_cyc [$];
  int rv_ch [$];
  int rv_val [$];
  int rv_cyc [$];
  int rv_mask [$];
  int hold_viol = 0;
  bit holding = 1'b0;
  logic [BIN_W-1:0] hold_val;

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    int d;
    d = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    return BCD_W'(d);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Converter model: answers L cycles after a conv_en pulse when alive.
  initial begin
    logic [BIN_W-1:0] b;
    int l;
    bif.conv_rdy = 1'b0;
    bif.conv_bcd = '0;
    forever begin
      @(negedge clk);
      if (bif.conv_en && alive) begin
        b = bif.conv_bin;
        l = lat;
        repeat (l) @(negedge clk);
        bif.conv_bcd = to_bcd(int'(b));
        bif.conv_rdy = 1'b1;
        @(negedge clk);
        bif.conv_rdy = 1'b0;
      end
    end
  end

  // Monitor: one observation per cycle, shortly after the rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      holding = 1'b0;
    end else begin
      if (holding && bif.conv_bin !== hold_val) hold_viol++;
      if (bif.conv_rdy || bif.err) holding = 1'b0;
      if (bif.conv_en) begin
        en_bin.push_back(int'(bif.conv_bin));
        en_cyc.push_back(cyc);
        holding  = 1'b1;
        hold_val = bif.conv_bin;
      end
      if (bif.err) err_cyc.push_back(cyc);
      for (int i = 0; i < NREQ; i++) begin
        if (bif.res_valid[i]) begin
          rv_ch.push_back(i);
          rv_val.push_back(int'(bif.res_bcd[i*BCD_W +: BCD_W]));
          rv_cyc.push_back(cyc);
          rv_mask.push_back(int'(bif.res_valid));
        end
      end
    end
  end

  task automatic clear_logs();
    en_bin.delete(); en_cyc.delete(); err_cyc.delete();
    rv_ch.delete(); rv_val.delete(); rv_cyc.delete(); rv_mask.delete();
    hold_viol = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bif.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_served = NREQ - 1;
    for (int i = 0; i < NREQ; i++) exp_res[i] = '0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic pulse(input logic [NREQ-1:0] mask);
    @(negedge clk);
    bif.req = mask;
    for (int i = 0; i < NREQ; i++) if (mask[i]) bif.bin_in[i*BIN_W +: BIN_W] = pbin[i];
    @(negedge clk);
    bif.req = '0;
    req_obs = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bif.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle busy still high after %0d cycles", n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Expected service order from the round-robin rule.
  task automatic rr_order(input logic [NREQ-1:0] mask, input int last, output int ord [$]);
    ord.delete();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (mask[i]) ord.push_back(i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bif.conv_en, bif.busy, bif.err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got en/busy/err=%b want 000", {bif.conv_en, bif.busy, bif.err});
    end
    checks++;
    if (bif.conv_bin !== '0 || bif.res_valid !== '0) begin
      failures++;
      $display("FAIL reset_bin_valid got conv_bin=%0d res_valid=%b want 0", bif.conv_bin, bif.res_valid);
    end
    checks++;
    if (bif.res_bcd !== '0) begin
      failures++;
      $display("FAIL reset_res got %h want 0", bif.res_bcd);
    end
  endtask

  task automatic test_single();
    do_reset();
    lat = 14;
    pbin[1] = 12'd987;
    pulse(4'b0010);
    wait_idle(200);
    exp_res[1] = 16'h0987;
    checks++;
    if (en_bin.size() != 1 || en_bin[0] != 987) begin
      failures++;
      $display("FAIL single_en got %0d pulses first=%0d want 1 pulse bin 987", en_bin.size(), (en_bin.size() > 0) ? en_bin[0] : -1);
    end
    checks++;
    if (en_cyc.size() != 1 || en_cyc[0] != req_obs + 1) begin
      failures++;
      $display("FAIL single_issue_latency got cyc %0d want %0d", (en_cyc.size() > 0) ? en_cyc[0] : -1, req_obs + 1);
    end
    checks++;
    if (rv_ch.size() != 1 || rv_ch[0] != 1 || rv_val[0] != 'h0987 || rv_mask[0] != 2) begin
      failures++;
      $display("FAIL single_result got %0d strobes ch=%0d val=%h mask=%b want 1 strobe ch1 0987 0010",
               rv_ch.size(), (rv_ch.size() > 0) ? rv_ch[0] : -1, (rv_val.size() > 0) ? rv_val[0] : -1,
               (rv_mask.size() > 0) ? rv_mask[0] : -1);
    end
    checks++;
    if (rv_cyc.size() != 1 || en_cyc.size() != 1 || rv_cyc[0] - en_cyc[0] != lat + 2) begin
      failures++;
      $display("FAIL single_result_latency got %0d want %0d",
               (rv_cyc.size() > 0 && en_cyc.size() > 0) ? rv_cyc[0] - en_cyc[0] : -1, lat + 2);
    end
    checks++;
    if (bif.res_bcd !== {exp_res[3], exp_res[2], exp_res[1], exp_res[0]} || err_cyc.size() != 0) begin
      failures++;
      $display("FAIL single_res_vector got %h errs=%0d want %h errs=0", bif.res_bcd, err_cyc.size(),
               {exp_res[3], exp_res[2], exp_res[1], exp_res[0]});
    end
  endtask

  task automatic test_simultaneous();
    int want_bin [4] = '{1, 22, 333, 4095};
    do_reset();
    lat = 3;
    for (int i = 0; i < NREQ; i++) pbin[i] = BIN_W'(want_bin[i]);
    pulse(4'b1111);
    wait_idle(300);
    checks++;
    if (en_bin.size() != 4) begin
      failures++;
      $display("FAIL simul_en_count got %0d want 4", en_bin.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (en_bin[i] != want_bin[i] || rv_ch.size() != 4 || rv_ch[i] != i || rv_val[i] != int'(to_bcd(want_bin[i]))) begin
          failures++;
          $display("FAIL simul_order slot %0d got bin=%0d ch=%0d val=%h want bin=%0d ch=%0d val=%h", i, en_bin[i],
                   (rv_ch.size() > i) ? rv_ch[i] : -1, (rv_val.size() > i) ? rv_val[i] : -1, want_bin[i], i, to_bcd(want_bin[i]));
        end
      end
    end
    checks++;
    if (bif.res_bcd !== {16'h4095, 16'h0333, 16'h0022, 16'h0001} || hold_viol != 0) begin
      failures++;
      $display("FAIL simul_res_vector got %h hold_viol=%0d want 4095033300220001 0", bif.res_bcd, hold_viol);
    end
  endtask

  task automatic test_round_robin();
    int bad = 0;
    do_reset();
    lat = 3;
    pbin[0] = BIN_W'($urandom_range(0, 4095));
    pbin[2] = BIN_W'($urandom_range(0, 4095));
    @(negedge clk);
    bif.bin_in[0*BIN_W +: BIN_W] = pbin[0];
    bif.bin_in[2*BIN_W +: BIN_W] = pbin[2];
    bif.req = 4'b0101;
    repeat (60) @(negedge clk);
    bif.req = '0;
    wait_idle(200);
    for (int i = 0; i < rv_ch.size(); i++) begin
      if (rv_ch[i] != 0 && rv_ch[i] != 2) bad++;
      else if (rv_val[i] != int'(to_bcd(int'(pbin[rv_ch[i]])))) bad++;
      if (i > 0 && rv_ch[i] == rv_ch[i-1]) bad++;
    end
    checks++;
    if (rv_ch.size() < 4 || rv_ch[0] != 0 || bad != 0) begin
      failures++;
      $display("FAIL round_robin got %0d results first=%0d violations=%0d want >=4 first=0 violations=0",
               rv_ch.size(), (rv_ch.size() > 0) ? rv_ch[0] : -1, bad);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    lat = 10;
    pbin[0] = 12'd42;
    pulse(4'b0001);
    pbin[3] = 12'd5;
    pulse(4'b1000);
    pbin[3] = 12'd9;
    pulse(4'b1000);
    wait_idle(200);
    checks++;
    if (en_bin.size() != 2 || en_bin[0] != 42 || en_bin[1] != 9) begin
      failures++;
      $display("FAIL overwrite_issue got %0d pulses second=%0d want 2 pulses second=9", en_bin.size(),
               (en_bin.size() > 1) ? en_bin[1] : -1);
    end
    checks++;
    if (rv_ch.size() != 2 || rv_ch[1] != 3 || rv_val[1] != 'h0009) begin
      failures++;
      $display("FAIL overwrite_result got %0d results last=%h want 2 results ch3=0009", rv_ch.size(),
               (rv_val.size() > 1) ? rv_val[1] : -1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    alive = 1'b0;
    pbin[2] = 12'd100;
    pulse(4'b0100);
    wait_idle(300);
    alive = 1'b1;
    checks++;
    if (err_cyc.size() != 1 || en_cyc.size() != 1 || err_cyc[0] - en_cyc[0] != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_err got %0d pulses delay=%0d want 1 pulse delay=%0d", err_cyc.size(),
               (err_cyc.size() > 0 && en_cyc.size() > 0) ? err_cyc[0] - en_cyc[0] : -1, TIMEOUT);
    end
    checks++;
    if (rv_ch.size() != 0 || bif.res_bcd[2*BCD_W +: BCD_W] !== '0) begin
      failures++;
      $display("FAIL timeout_res got %0d strobes ch2=%h want 0 strobes ch2=0", rv_ch.size(), bif.res_bcd[2*BCD_W +: BCD_W]);
    end
    clear_logs();
    lat = 6;
    pulse(4'b0100);
    wait_idle(200);
    checks++;
    if (rv_ch.size() != 1 || rv_val[0] != 'h0100 || err_cyc.size() != 0) begin
      failures++;
      $display("FAIL timeout_recover got %0d results val=%h errs=%0d want 1 result 0100 errs=0", rv_ch.size(),
               (rv_val.size() > 0) ? rv_val[0] : -1, err_cyc.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    lat = 4;
    pbin[0] = 12'd321;
    pulse(4'b0001);
    wait_idle(200);
    lat = 20;
    pbin[1] = BIN_W'($urandom_range(1, 4095));
    pulse(4'b0010);
    repeat (5) @(negedge clk);
    clear_logs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rv_ch.size() != 0 || en_bin.size() != 0 || err_cyc.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_wait_events got strobes=%0d en=%0d err=%0d want 0 0 0", rv_ch.size(), en_bin.size(), err_cyc.size());
    end
    checks++;
    if (bif.res_bcd !== '0 || bif.busy !== 1'b0 || bif.conv_bin !== '0 || bif.res_valid !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait_outputs got res=%h busy=%b bin=%0d want 0 0 0", bif.res_bcd, bif.busy, bif.conv_bin);
    end
  endtask

  task automatic test_random();
    int ord [$];
    logic [NREQ-1:0] mask;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      int bad = 0;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      lat = $urandom_range(1, 12);
      for (int i = 0; i < NREQ; i++) pbin[i] = BIN_W'($urandom_range(0, 4095));
      clear_logs();
      rr_order(mask, last_served, ord);
      pulse(mask);
      wait_idle(400);
      if (en_bin.size() != ord.size() || rv_ch.size() != ord.size()) bad++;
      else begin
        for (int k = 0; k < ord.size(); k++) begin
          if (en_bin[k] != int'(pbin[ord[k]]) || rv_ch[k] != ord[k] || rv_val[k] != int'(to_bcd(int'(pbin[ord[k]])))) bad++;
        end
      end
      for (int k = 0; k < ord.size(); k++) exp_res[ord[k]] = to_bcd(int'(pbin[ord[k]]));
      last_served = ord[ord.size() - 1];
      checks++;
      if (bad != 0 || hold_viol != 0 || bif.res_bcd !== {exp_res[3], exp_res[2], exp_res[1], exp_res[0]}) begin
        failures++;
        $display("FAIL random round %0d mask=%b got %0d issues res=%h hold_viol=%0d want %0d issues res=%h", r, mask,
                 en_bin.size(), bif.res_bcd, hold_viol, ord.size(), {exp_res[3], exp_res[2], exp_res[1], exp_res[0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.req = '0;
    bif.bin_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      pbin[i] = '0;
      exp_res[i] = '0;
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_overwrite();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
